// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/acceptance/grant signals shared by the caches, the bus sequencer and the arbiter.
interface bus_arbiter_if #(
    parameter int num_caches_p = 2
);
    localparam int id_width_lp = ($clog2(num_caches_p) > 1) ? $clog2(num_caches_p) : 1;
    logic [num_caches_p-1:0] req_i;
    logic                    done_i;
    logic [num_caches_p-1:0] yumi_o;
    logic [num_caches_p-1:0] grant_o;
    logic [id_width_lp-1:0]  grant_id_o;
    logic                    busy_o;
    logic                    tx_start_o;
    logic                    err_o;
    modport master (
        output req_i, done_i,
        input  yumi_o, grant_o, grant_id_o, busy_o, tx_start_o, err_o
    );
    modport slave (
        input  req_i, done_i,
        output yumi_o, grant_o, grant_id_o, busy_o, tx_start_o, err_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for the shared snooping bus; grant held from yumi until done.
module bus_arbiter #(
    parameter int num_caches_p = 2
) (
    input logic          clk_i,
    input logic          nreset_i,
    bus_arbiter_if.slave bus
);
    localparam int id_width_lp = ($clog2(num_caches_p) > 1) ? $clog2(num_caches_p) : 1;

    typedef enum logic [1:0] {IDLE, ACCEPT, BUSY} state_t;

    state_t                  state, state_n;
    logic [num_caches_p-1:0] grant, grant_n;
    logic [id_width_lp-1:0]  grant_id, grant_id_n, rr_ptr, rr_ptr_n, pick, idx;
    logic                    found, err, err_n;

    // scan starting at rr_ptr so the most recent owner gets lowest priority
    always_comb begin
        pick = '0;
        idx = '0;
        found = 1'b0;
        for (int i = 0; i < num_caches_p; i++) begin
            idx = id_width_lp'((int'(rr_ptr) + i) % num_caches_p);
            if (!found && bus.req_i[idx]) begin
                found = 1'b1;
                pick = idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        grant_id_n = grant_id;
        rr_ptr_n = rr_ptr;
        err_n = err;
        if (state == IDLE && found) begin
            state_n = ACCEPT;
            grant_n = num_caches_p'(1) << pick;
            grant_id_n = pick;
        end
        if (state == ACCEPT)
            state_n = BUSY;
        if (state == BUSY && bus.done_i) begin
            state_n = IDLE;
            grant_n = '0;
            rr_ptr_n = (grant_id == id_width_lp'(num_caches_p - 1)) ? '0 : grant_id + 1'b1;
        end
        // stray done outside a transaction, or requester withdrawing before its yumi
        if ((state != BUSY && bus.done_i) || (state == ACCEPT && !bus.req_i[grant_id]))
            err_n = 1'b1;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state <= IDLE;
            grant <= '0;
            grant_id <= '0;
            rr_ptr <= '0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            grant_id <= grant_id_n;
            rr_ptr <= rr_ptr_n;
            err <= err_n;
        end
    end

    assign bus.yumi_o = (state == ACCEPT) ? grant : '0;
    assign bus.tx_start_o = (state == ACCEPT);
    assign bus.busy_o = (state != IDLE);
    assign bus.grant_o = grant;
    assign bus.grant_id_o = grant_id;
    assign bus.err_o = err;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenario tests for bus_arbiter with four caches.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    int compared = 0;
    int mismatched = 0;

    bus_arbiter_if #(.num_caches_p(4)) bif ();
    bus_arbiter #(.num_caches_p(4)) dut (.clk_i(clk), .nreset_i(nreset), .bus(bif.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bif.req_i = '0;
        bif.done_i = 1'b0;
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        tick();
    endtask

    task automatic pulse_done();
        bif.done_i = 1'b1;
        tick();
        bif.done_i = 1'b0;
    endtask

    task automatic test_reset();
        bif.req_i = '0;
        bif.done_i = 1'b0;
        nreset = 1'b0;
        #12;
        compared++;
        if ({bif.yumi_o, bif.grant_o, bif.grant_id_o, bif.busy_o, bif.tx_start_o, bif.err_o} !== 14'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h required 0",
                     {bif.yumi_o, bif.grant_o, bif.grant_id_o, bif.busy_o, bif.tx_start_o, bif.err_o});
        end
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        bif.req_i = 4'b0100;
        tick();
        compared++;
        if ({bif.yumi_o, bif.tx_start_o, bif.grant_id_o} !== {4'b0100, 1'b1, 2'd2}) begin
            mismatched++;
            $display("FAIL single_yumi: got yumi=%b tx=%b id=%0d required yumi=0100 tx=1 id=2",
                     bif.yumi_o, bif.tx_start_o, bif.grant_id_o);
        end
        tick();
        bif.req_i = '0;
        compared++;
        if ({bif.yumi_o, bif.tx_start_o, bif.busy_o, bif.grant_o} !== {4'b0000, 1'b0, 1'b1, 4'b0100}) begin
            mismatched++;
            $display("FAIL single_busy: got yumi=%b tx=%b busy=%b grant=%b required 0000 0 1 0100",
                     bif.yumi_o, bif.tx_start_o, bif.busy_o, bif.grant_o);
        end
        tick();
        pulse_done();
        compared++;
        if ({bif.busy_o, bif.grant_o, bif.err_o} !== 6'b0_0000_0) begin
            mismatched++;
            $display("FAIL single_release: got busy=%b grant=%b err=%b required 0 0000 0",
                     bif.busy_o, bif.grant_o, bif.err_o);
        end
    endtask

    // relies on rr_ptr=3 left by test_single
    task automatic test_wrap();
        bif.req_i = 4'b0011;
        tick();
        compared++;
        if (bif.grant_id_o !== 2'd0 || bif.yumi_o !== 4'b0001) begin
            mismatched++;
            $display("FAIL wrap_first: got id=%0d yumi=%b required id=0 yumi=0001", bif.grant_id_o, bif.yumi_o);
        end
        tick();
        tick();
        pulse_done();
        tick();
        compared++;
        if (bif.grant_id_o !== 2'd1 || bif.yumi_o !== 4'b0010) begin
            mismatched++;
            $display("FAIL wrap_second: got id=%0d yumi=%b required id=1 yumi=0010", bif.grant_id_o, bif.yumi_o);
        end
        tick();
        bif.req_i = '0;
        pulse_done();
    endtask

    task automatic test_fairness();
        logic [3:0] onehot;
        do_reset();
        bif.req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            onehot = 4'b0001 << (k % 4);
            tick();
            compared++;
            if (bif.yumi_o !== onehot || bif.grant_id_o !== 2'(k % 4) || $countones(bif.yumi_o) != 1) begin
                mismatched++;
                $display("FAIL fair_grant_%0d: got yumi=%b id=%0d required yumi=%b id=%0d",
                         k, bif.yumi_o, bif.grant_id_o, onehot, k % 4);
            end
            tick();
            tick();
            tick();
            pulse_done();
            compared++;
            if (bif.busy_o !== 1'b0 || bif.yumi_o !== 4'b0000) begin
                mismatched++;
                $display("FAIL fair_bubble_%0d: got busy=%b yumi=%b required 0 0000", k, bif.busy_o, bif.yumi_o);
            end
        end
        bif.req_i = '0;
        compared++;
        if (bif.err_o !== 1'b0) begin
            mismatched++;
            $display("FAIL fair_no_err: got err=%b required 0", bif.err_o);
        end
    endtask

    task automatic test_done_idle();
        do_reset();
        pulse_done();
        compared++;
        if (bif.err_o !== 1'b1 || bif.busy_o !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_done_err: got err=%b busy=%b required 1 0", bif.err_o, bif.busy_o);
        end
        tick();
        tick();
        bif.req_i = 4'b0001;
        tick();
        compared++;
        if (bif.err_o !== 1'b1 || bif.yumi_o !== 4'b0001) begin
            mismatched++;
            $display("FAIL idle_done_sticky: got err=%b yumi=%b required 1 0001", bif.err_o, bif.yumi_o);
        end
        tick();
        bif.req_i = '0;
        pulse_done();
    endtask

    task automatic test_accept_drop();
        do_reset();
        bif.req_i = 4'b0010;
        tick();
        bif.req_i = '0;
        tick();
        compared++;
        if (bif.err_o !== 1'b1 || bif.grant_o !== 4'b0010) begin
            mismatched++;
            $display("FAIL accept_drop: got err=%b grant=%b required 1 0010", bif.err_o, bif.grant_o);
        end
        pulse_done();
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse_done();
        bif.req_i = 4'b0010;
        tick();
        tick();
        bif.req_i = '0;
        compared++;
        if (bif.grant_o !== 4'b0010 || bif.err_o !== 1'b1) begin
            mismatched++;
            $display("FAIL areset_pre: got grant=%b err=%b required 0010 1", bif.grant_o, bif.err_o);
        end
        #3 nreset = 1'b0;
        #1;
        compared++;
        if ({bif.grant_o, bif.busy_o, bif.err_o} !== 6'b0) begin
            mismatched++;
            $display("FAIL areset_now: got grant=%b busy=%b err=%b required 0000 0 0",
                     bif.grant_o, bif.busy_o, bif.err_o);
        end
        #2 nreset = 1'b1;
        bif.req_i = 4'b0110;
        tick();
        compared++;
        if (bif.yumi_o !== 4'b0010 || bif.grant_id_o !== 2'd1) begin
            mismatched++;
            $display("FAIL areset_regrant: got yumi=%b id=%0d required 0010 1", bif.yumi_o, bif.grant_id_o);
        end
        tick();
        bif.req_i = '0;
        pulse_done();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bif.req_i = 4'b0001;
        tick();
        tick();
        bif.req_i = 4'b1000;
        tick();
        compared++;
        if (bif.yumi_o !== 4'b0000 || bif.grant_o !== 4'b0001) begin
            mismatched++;
            $display("FAIL b2b_ignored: got yumi=%b grant=%b required 0000 0001", bif.yumi_o, bif.grant_o);
        end
        pulse_done();
        compared++;
        if (bif.busy_o !== 1'b0 || bif.yumi_o !== 4'b0000) begin
            mismatched++;
            $display("FAIL b2b_bubble: got busy=%b yumi=%b required 0 0000", bif.busy_o, bif.yumi_o);
        end
        tick();
        compared++;
        if (bif.yumi_o !== 4'b1000 || bif.grant_id_o !== 2'd3 || bif.err_o !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_next: got yumi=%b id=%0d err=%b required 1000 3 0",
                     bif.yumi_o, bif.grant_id_o, bif.err_o);
        end
        tick();
        bif.req_i = '0;
        pulse_done();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_fairness();
        test_done_idle();
        test_accept_drop();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
